// File: rtl/gpu_pkg.sv
// gpu_pkg: shared VRAM arbiter types and widths
// requester IDs, arbiter states, bus sizes
package gpu_pkg;

  localparam int VRAM_ADDR_W = 20;
  localparam int VRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_DISP = 2'd1,
    REQ_XFER = 2'd2,
    REQ_DRAW = 2'd3
  } vram_req_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// vram_rd_tag_pipe: requester-ID shift pipe for reads
// tag_due marks data on the bus now, tag_out marks return
module vram_rd_tag_pipe
  import gpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  vram_req_id_t tag_in,
  output vram_req_id_t tag_due,
  output vram_req_id_t tag_out,
  output logic         nonempty
);

  vram_req_id_t pipe [DEPTH];

  // shift one slot per cycle, empty slots for writes/idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        pipe[i] <= REQ_NONE;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign tag_due = pipe[DEPTH-2];
  assign tag_out = pipe[DEPTH-1];

  // any read still waiting for its data
  always_comb begin
    nonempty = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (pipe[i] != REQ_NONE)
        nonempty = 1'b1;
  end

endmodule

// File: rtl/gpu_vram_arbiter.sv
// gpu_vram_arbiter: single-port VRAM arbiter
// disp > burst owner > xfer/draw round-robin
module gpu_vram_arbiter
  import gpu_pkg::*;
#(
  parameter int ADDR_W    = VRAM_ADDR_W,
  parameter int DATA_W    = VRAM_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  input  logic              xfer_req,
  input  logic              xfer_we,
  input  logic [ADDR_W-1:0] xfer_addr,
  input  logic [DATA_W-1:0] xfer_wdata,
  output logic              xfer_gnt,
  output logic              xfer_rvalid,
  input  logic              draw_req,
  input  logic              draw_we,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_wdata,
  output logic              draw_gnt,
  output logic              draw_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic              vram_we,
  output logic              vram_oe,
  output logic              vram_drive,
  input  logic [DATA_W-1:0] vram_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  arb_state_t   state, state_nx;
  vram_req_id_t owner, rr_ptr, win;
  vram_req_id_t tag_in, tag_due, tag_out;
  logic [CNT_W-1:0] burst_cnt;
  logic own_req, keep_own, new_burst;
  logic win_we, blk_raw, blk_war, acc, rd_busy;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign own_req =
    (owner == REQ_XFER && xfer_req) ||
    (owner == REQ_DRAW && draw_req);
  assign keep_own =
    state != IDLE && own_req &&
    burst_cnt != MAX_CNT;

  // winner: disp preempts, then owner, then round-robin
  always_comb begin
    win = REQ_NONE;
    if (disp_req) begin
      win = REQ_DISP;
    end else if (keep_own) begin
      win = owner;
    end else if (rr_ptr == REQ_DRAW) begin
      if (draw_req)      win = REQ_DRAW;
      else if (xfer_req) win = REQ_XFER;
    end else begin
      if (xfer_req)      win = REQ_XFER;
      else if (draw_req) win = REQ_DRAW;
    end
  end

  // route the winner's access fields
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    unique case (1'b1)
      (win == REQ_DISP): begin
        win_addr = disp_addr;
      end
      (win == REQ_XFER): begin
        win_we    = xfer_we;
        win_addr  = xfer_addr;
        win_wdata = xfer_wdata;
      end
      (win == REQ_DRAW): begin
        win_we    = draw_we;
        win_addr  = draw_addr;
        win_wdata = draw_wdata;
      end
      default: ;
    endcase
  end

  // read right after a write needs a turnaround cycle;
  // a write waits for all reads to return
  assign blk_raw = win != REQ_NONE && !win_we && vram_we;
  assign blk_war = win_we && rd_busy;
  assign new_burst = win != owner || burst_cnt == MAX_CNT;

  // next state from winner and hazards
  always_comb begin
    state_nx = IDLE;
    if (win != REQ_NONE)
      state_nx = blk_raw ? TURN : OWN;
  end

  // grant outputs: only an unblocked winner
  always_comb begin
    acc = !rst && win != REQ_NONE &&
          !blk_raw && !blk_war;
    disp_gnt = 1'b0;
    xfer_gnt = 1'b0;
    draw_gnt = 1'b0;
    unique case (1'b1)
      (acc && win == REQ_DISP): disp_gnt = 1'b1;
      (acc && win == REQ_XFER): xfer_gnt = 1'b1;
      (acc && win == REQ_DRAW): draw_gnt = 1'b1;
      default: ;
    endcase
  end

  // state, ownership, burst count and rr pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= REQ_NONE;
      rr_ptr    <= REQ_XFER;
      burst_cnt <= '0;
    end else begin
      state <= state_nx;
      if (win == REQ_NONE) begin
        owner     <= REQ_NONE;
        burst_cnt <= '0;
      end else if (acc) begin
        if (new_burst) begin
          owner     <= win;
          burst_cnt <= ONE_CNT;
          if (win == REQ_XFER)      rr_ptr <= REQ_DRAW;
          else if (win == REQ_DRAW) rr_ptr <= REQ_XFER;
        end else if (burst_cnt != MAX_CNT) begin
          burst_cnt <= burst_cnt + ONE_CNT;
        end
      end
    end
  end

  // register the accepted access onto the VRAM pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_addr  <= '0;
      vram_wdata <= '0;
      vram_we    <= 1'b0;
      vram_oe    <= 1'b0;
    end else begin
      vram_we <= acc && win_we;
      vram_oe <= acc && !win_we;
      if (acc) vram_addr <= win_addr;
      if (acc && win_we) vram_wdata <= win_wdata;
    end
  end

  assign vram_drive = vram_we;
  assign tag_in = (acc && !win_we) ? win : REQ_NONE;

  vram_rd_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_tags (
    .clk      (clk),
    .rst      (rst),
    .tag_in   (tag_in),
    .tag_due  (tag_due),
    .tag_out  (tag_out),
    .nonempty (rd_busy)
  );

  // capture bus data on the edge the read is due
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= (tag_due != REQ_NONE) ? vram_rdata : '0;
  end

  assign disp_rvalid = tag_out == REQ_DISP;
  assign xfer_rvalid = tag_out == REQ_XFER;
  assign draw_rvalid = tag_out == REQ_DRAW;

endmodule
